// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, MUL/DIV op encodings and execute-unit state type
package cpu_pkg;

  localparam int CPU_WIDTH      = 16;
  localparam int CPU_REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - issue-side operands and register-file write port of the MUL/DIV unit
interface mul_div_unit_if #(
  parameter int WIDTH      = cpu_pkg::CPU_WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::CPU_REG_ADDR_W
);
  logic                  start;
  logic                  abort;
  logic [1:0]            op;
  logic [WIDTH-1:0]      REG_DATA1;
  logic [WIDTH-1:0]      REG_DATA2;
  logic [REG_ADDR_W-1:0] TGT_in;
  logic                  busy;
  logic [REG_ADDR_W-1:0] TGT;
  logic [WIDTH-1:0]      RF_write_data;
  logic                  write_en_reg;

  modport master (
    output start, abort, op, REG_DATA1, REG_DATA2, TGT_in,
    input  busy, TGT, RF_write_data, write_en_reg
  );

  modport slave (
    input  start, abort, op, REG_DATA1, REG_DATA2, TGT_in,
    output busy, TGT, RF_write_data, write_en_reg
  );
endinterface

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - one-bit-per-step shift-add multiplier / restoring divider
module md_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  // hi: product upper half / partial remainder; lo: multiplier / quotient
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, b_q} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {2'b00, b_q};
    hi_n      = '0;
    lo_n      = '0;
    if (div_q) begin
      if (!div_diff[WIDTH+1]) begin
        hi_n = div_diff[WIDTH:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_shift[WIDTH:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = {1'b0, mul_sum[WIDTH:1]};
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  assign hi_next = hi_n[WIDTH-1:0];
  assign lo_next = lo_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi    <= '0;
      div_q <= is_div;
      lo    <= is_div ? a_in : b_in;
      b_q   <= is_div ? b_in : a_in;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MUL/MULHU/DIVU/REMU execute unit driving the register-file write port
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH      = CPU_WIDTH,
  parameter int REG_ADDR_W = CPU_REG_ADDR_W
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_t             state;
  md_state_t             state_next;
  logic [CNT_W-1:0]      count;
  md_op_t                op_q;
  logic [REG_ADDR_W-1:0] tgt_q;

  logic                  accept;
  logic                  div_zero;
  logic                  last_step;
  logic [WIDTH-1:0]      hi_next;
  logic [WIDTH-1:0]      lo_next;
  logic [WIDTH-1:0]      result_run;
  logic [WIDTH-1:0]      result_dz;

  // abort outranks a simultaneous start in IDLE
  assign accept    = (state == IDLE) && bus.start && !bus.abort;
  assign div_zero  = bus.op[1] && (bus.REG_DATA2 == '0);
  assign last_step = (state == RUN) && !bus.abort && (count == CNT_W'(1));

  // MULHU and REMU take the upper register, MUL and DIVU the lower
  assign result_run = op_q[0] ? hi_next : lo_next;
  assign result_dz  = (md_op_t'(bus.op) == MD_DIVU) ? '1 : bus.REG_DATA1;

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && !div_zero),
    .step    ((state == RUN) && !bus.abort),
    .is_div  (bus.op[1]),
    .a_in    (bus.REG_DATA1),
    .b_in    (bus.REG_DATA2),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = div_zero ? DONE : RUN;
      RUN: begin
        if (bus.abort)                  state_next = IDLE;
        else if (count == CNT_W'(1))    state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state != IDLE);
    bus.write_en_reg = (state == DONE) && !bus.abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      op_q  <= MD_MUL;
      tgt_q <= '0;
    end else if (accept) begin
      count <= CNT_W'(WIDTH);
      op_q  <= md_op_t'(bus.op);
      tgt_q <= bus.TGT_in;
    end else if (state == RUN) begin
      count <= bus.abort ? '0 : count - CNT_W'(1);
    end
  end

  // write-port registers only change on entry to DONE, so they hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.TGT           <= '0;
      bus.RF_write_data <= '0;
    end else if (accept && div_zero) begin
      bus.TGT           <= bus.TGT_in;
      bus.RF_write_data <= result_dz;
    end else if (last_step) begin
      bus.TGT           <= tgt_q;
      bus.RF_write_data <= result_run;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] tgt, output logic [15:0] data, output logic [2:0] tgt_o,
                        output int wcyc, output int pulses, output int busy_cnt);
    data = '0; tgt_o = '0; wcyc = -1; pulses = 0; busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.REG_DATA1 = a; bus.REG_DATA2 = b; bus.TGT_in = tgt;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus.write_en_reg) begin
        pulses++; wcyc = k; data = bus.RF_write_data; tgt_o = bus.TGT;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total += 4;
    if (bus.busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    if (bus.write_en_reg !== 1'b0)  begin bad++; $display("FAIL reset_we got=%b want=0", bus.write_en_reg); end
    if (bus.TGT !== 3'd0)           begin bad++; $display("FAIL reset_tgt got=%0d want=0", bus.TGT); end
    if (bus.RF_write_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", bus.RF_write_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_ops;
    logic [1:0]  ops  [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [15:0] va   [8] = '{16'd3, 16'hFFFF, 16'hFFFF, 16'd100, 16'd100, 16'h8000, 16'd1234, 16'd1234};
    logic [15:0] vb   [8] = '{16'd5, 16'hFFFF, 16'hFFFF, 16'd7, 16'd7, 16'd1, 16'd0, 16'd0};
    logic [15:0] exp  [8] = '{16'h000F, 16'h0001, 16'hFFFE, 16'h000E, 16'h0002, 16'h8000, 16'hFFFF, 16'h04D2};
    logic [2:0]  tgts [8] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    int          cyc  [8] = '{17, 17, 17, 17, 17, 17, 1, 1};
    logic [15:0] data;
    logic [2:0]  tgt_o;
    int          wcyc, pulses, busy_cnt;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], va[i], vb[i], tgts[i], data, tgt_o, wcyc, pulses, busy_cnt);
      total += 5;
      if (pulses !== 1)     begin bad++; $display("FAIL op%0d_pulses got=%0d want=1", i, pulses); end
      if (wcyc !== cyc[i])  begin bad++; $display("FAIL op%0d_cycle got=%0d want=%0d", i, wcyc, cyc[i]); end
      if (busy_cnt !== cyc[i]) begin bad++; $display("FAIL op%0d_busy got=%0d want=%0d", i, busy_cnt, cyc[i]); end
      if (data !== exp[i])  begin bad++; $display("FAIL op%0d_data got=%h want=%h", i, data, exp[i]); end
      if (tgt_o !== tgts[i]) begin bad++; $display("FAIL op%0d_tgt got=%0d want=%0d", i, tgt_o, tgts[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int          pulses = 0, busy_cnt = 0;
    logic [15:0] data = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.REG_DATA1 = 16'd6; bus.REG_DATA2 = 16'd7; bus.TGT_in = 3'd3;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.REG_DATA1 = 16'd9; bus.REG_DATA2 = 16'd9; bus.TGT_in = 3'd5;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.write_en_reg) begin pulses++; data = bus.RF_write_data; end
      if (bus.busy) busy_cnt++;
      bus.start = (k == 3 || k == 17);
    end
    total += 4;
    if (pulses !== 1)      begin bad++; $display("FAIL b2b_pulses got=%0d want=1", pulses); end
    if (busy_cnt !== 17)   begin bad++; $display("FAIL b2b_busy got=%0d want=17", busy_cnt); end
    if (data !== 16'd42)   begin bad++; $display("FAIL b2b_data got=%h want=002a", data); end
    if (bus.TGT !== 3'd3)  begin bad++; $display("FAIL b2b_tgt got=%0d want=3", bus.TGT); end
  endtask

  task automatic test_abort;
    int pulses = 0;
    logic busy_after = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.REG_DATA1 = 16'd11; bus.REG_DATA2 = 16'd13; bus.TGT_in = 3'd6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bus.write_en_reg) pulses++;
      if (k == 9) busy_after = bus.busy;
      bus.abort = (k == 8);
    end
    total += 4;
    if (pulses !== 0)        begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    if (busy_after !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_after); end
    if (bus.TGT !== 3'd3)    begin bad++; $display("FAIL abort_tgt_hold got=%0d want=3", bus.TGT); end
    if (bus.RF_write_data !== 16'd42) begin bad++; $display("FAIL abort_data_hold got=%h want=002a", bus.RF_write_data); end
    // abort and start together in IDLE: start must be dropped
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    total += 1;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0, busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.REG_DATA1 = 16'd5; bus.REG_DATA2 = 16'd5; bus.TGT_in = 3'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total += 4;
    if (bus.busy !== 1'b0)           begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    if (bus.write_en_reg !== 1'b0)   begin bad++; $display("FAIL rstmid_we got=%b want=0", bus.write_en_reg); end
    if (bus.TGT !== 3'd0)            begin bad++; $display("FAIL rstmid_tgt got=%0d want=0", bus.TGT); end
    if (bus.RF_write_data !== 16'h0) begin bad++; $display("FAIL rstmid_data got=%h want=0000", bus.RF_write_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.write_en_reg) pulses++;
      if (bus.busy) busy_cnt++;
    end
    total += 2;
    if (pulses !== 0)   begin bad++; $display("FAIL rstmid_pulses got=%0d want=0", pulses); end
    if (busy_cnt !== 0) begin bad++; $display("FAIL rstmid_busycnt got=%0d want=0", busy_cnt); end
  endtask

  task automatic test_fresh;
    logic [15:0] data;
    logic [2:0]  tgt_o;
    int          wcyc, pulses, busy_cnt;
    run_op(2'b00, 16'd2, 16'd2, 3'd1, data, tgt_o, wcyc, pulses, busy_cnt);
    total += 4;
    if (pulses !== 1)   begin bad++; $display("FAIL fresh_pulses got=%0d want=1", pulses); end
    if (wcyc !== 17)    begin bad++; $display("FAIL fresh_cycle got=%0d want=17", wcyc); end
    if (data !== 16'd4) begin bad++; $display("FAIL fresh_data got=%h want=0004", data); end
    if (tgt_o !== 3'd1) begin bad++; $display("FAIL fresh_tgt got=%0d want=1", tgt_o); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.op = 2'b00;
    bus.REG_DATA1 = '0; bus.REG_DATA2 = '0; bus.TGT_in = '0;
    repeat (2) @(posedge clk);
    test_reset;
    test_ops;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_fresh;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle execute unit for the 16-bit core's MUL/DIV instruction class. It sits directly downstream of the register file: it captures the two read operands (REG_DATA1/REG_DATA2) and the destination index, then iterates one bit per cycle. It drives the register-file write port (TGT, RF_write_data, write_en_reg) with a one-cycle write pulse when the result is ready.

Parameters:
WIDTH, 16, operand and result width
REG_ADDR_W, 3, register index width (8 architectural registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request a new operation; sampled only in IDLE
abort  input  1  synchronous flush; cancels an in-flight operation without writeback
op  input  2  00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU (quotient), 11 REMU (remainder)
REG_DATA1  input  WIDTH  operand A (multiplicand / dividend)
REG_DATA2  input  WIDTH  operand B (multiplier / divisor)
TGT_in  input  REG_ADDR_W  destination register index
busy  output  1  high in RUN and DONE; the issue stage stalls while high
TGT  output  REG_ADDR_W  destination index to the register file
RF_write_data  output  WIDTH  result to the register file
write_en_reg  output  1  one-cycle register-file write strobe

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n. While rst_n=0: state=IDLE, busy=0, write_en_reg=0, TGT=0, RF_write_data=0, counter=0, all datapath registers=0.
- States:
  - IDLE: on start=1, capture A, B, op and TGT_in. If op[1]=1 and B==0, go to DONE; otherwise clear the accumulator, set count=WIDTH and go to RUN. start is ignored in RUN and DONE, with no queueing.
  - RUN: one iteration per cycle. Decrement count; when count reaches 1, go to DONE on the next edge.
  - DONE: write_en_reg=1 for exactly one cycle, with RF_write_data and TGT valid in that same cycle. Next state is IDLE.
- Latency: start at edge N gives write_en_reg high in cycle N+17 (16 RUN + 1 DONE). Divide-by-zero gives write_en_reg high in cycle N+1. busy is asserted from the edge after start until DONE exits.
- Multiply: unsigned shift-add into a 2*WIDTH product register.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift right by 1 with carry-in (WIDTH+1-bit add).
  - MUL returns product[15:0]. MULHU returns product[31:16].
- Divide: unsigned restoring division with a WIDTH+1-bit partial remainder.
  - Each cycle: shift {rem, quot} left by 1; trial-subtract B.
  - If the trial is non-negative, keep the result and set the quotient LSB to 1; otherwise restore and set it to 0.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: DIVU returns 0xFFFF; REMU returns A. No exception is raised.
- abort=1 in RUN or DONE: next state is IDLE, write_en_reg stays 0, TGT/RF_write_data hold. abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and start is dropped.
- Reset asserted mid-operation: immediate return to the reset values. No write is issued after release.
- TGT/RF_write_data are registered and hold their last value outside DONE. Consumers qualify them with write_en_reg only.

Decomposition:
- Shared package cpu_pkg:
  - WIDTH and REG_ADDR_W defaults
  - op encodings MD_MUL, MD_MULHU, MD_DIVU, MD_REMU
  - state typedef md_state_t {IDLE, RUN, DONE}
- Optional sub-module md_datapath: iterative add/subtract-shift datapath with a step/load interface. The FSM and handshake stay in mul_div_unit.

Test Plan:
- MUL 3 x 5, TGT_in=2 -> write_en_reg pulses exactly in cycle N+17 with TGT=2, RF_write_data=0x000F; busy high for 17 cycles.
- 0xFFFF x 0xFFFF -> MUL returns 0x0001; MULHU returns 0xFFFE.
- DIVU 100/7 returns 0x000E; REMU 100/7 returns 0x0002. DIVU 0x8000/1 returns 0x8000.
- DIVU 1234/0 returns 0xFFFF and REMU 1234/0 returns 0x04D2, each at cycle N+1 with busy high for 1 cycle.
- start re-asserted at cycles N+3 and N+17 during a MUL -> only one write pulse occurs; the second request is not executed.
- abort at N+8 returns to IDLE with no write pulse. rst_n pulled low at N+5 forces all outputs to 0 immediately and produces no write after release. A fresh MUL 2 x 2 then returns 4 normally.
